// File: rtl/dm_ctrl_if.sv
// Host load/dump port of the data-memory controller.
//   valid/we/addr/wdata : request from the host (UART side)
//   ready               : request accepted when valid & ready
//   rvalid/rdata        : one-cycle read-data return
// master = host side, slave = dm_ctrl side.
interface dm_ctrl_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 12
) ();
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory controller sitting downstream of the processor core.
// Owns the data RAM, arbitrates it between the host load/dump port and the
// core, and sequences the core through HOST -> RUN -> DONE.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   dm_en        : core write strobe
//   ar_out       : core address
//   bus_out      : core bus, low DATA_W bits are write data
//   end_process  : core finished (RUN -> DONE)
//   dm_out       : registered read data at ar_out (updated only in RUN)
//   run_en       : core enable, high only in RUN
//   host         : host request/response port (dm_ctrl_if.slave)
//   host_go      : start/restart pulse from HOST or DONE
//   done         : high in DONE
//   cycle_count  : RUN cycle counter, present only when DM_CYCLE_CNT_EN is defined
// Optional feature macro: DM_CYCLE_CNT_EN
module dm_ctrl #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_en,
  input  logic [ADDR_W-1:0] ar_out,
  input  logic [16:0]       bus_out,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic              run_en,
  dm_ctrl_if.slave          host,
  input  logic              host_go,
`ifdef DM_CYCLE_CNT_EN
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
`else
  output logic              done
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BUS_W = 17;

  typedef enum logic [1:0] {
    ST_HOST = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              host_ph;
  logic              accept;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IDX_W-1:0]  core_idx;
  logic [IDX_W-1:0]  host_idx;
  logic              unused_bits;

  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits are ignored (wrap-around); upper bus bits are not stored.
  assign core_idx    = ar_out[IDX_W-1:0];
  assign host_idx    = host.addr[IDX_W-1:0];
  assign unused_bits = ^{bus_out[BUS_W-1:DATA_W], ar_out[ADDR_W-1:IDX_W],
                         host.addr[ADDR_W-1:IDX_W]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, host acceptance and RAM write-port select.
  always_comb begin
    state_d   = ST_HOST;
    host_ph   = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      ST_HOST, ST_DONE: begin
        host_ph = 1'b1;
        state_d = host_go ? ST_RUN : state_q;
      end
      ST_RUN: begin
        state_d = end_process ? ST_DONE : ST_RUN;
      end
      default: state_d = ST_HOST;
    endcase
    // One outstanding read at a time: ready is withheld during the rvalid cycle.
    accept = host_ph & host.valid & ~rvalid_q;
    if (state_q == ST_RUN && dm_en) begin
      mem_we    = 1'b1;
      mem_waddr = core_idx;
      mem_wdata = bus_out[DATA_W-1:0];
    end else if (accept && host.we) begin
      mem_we    = 1'b1;
      mem_waddr = host_idx;
      mem_wdata = host.wdata;
    end
  end

  assign host.ready  = host_ph & ~rvalid_q;
  assign host.rvalid = rvalid_q;
  assign host.rdata  = rdata_q;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered outputs; reads sample the pre-write word (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_out   <= '0;
      run_en   <= 1'b0;
      done     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      run_en   <= (state_d == ST_RUN);
      done     <= (state_d == ST_DONE);
      rvalid_q <= accept & ~host.we;
      if (accept && !host.we) begin
        rdata_q <= mem[host_idx];
      end
      if (state_q == ST_RUN) begin
        dm_out <= mem[core_idx];
      end
    end
  end

`ifdef DM_CYCLE_CNT_EN
  // RUN cycle counter: cleared on entry to RUN, saturating, holds elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state_q != ST_RUN && state_d == ST_RUN) begin
      cycle_count <= '0;
    end else if (state_q == ST_RUN && cycle_count != {CNT_W{1'b1}}) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a phase/array reference model.
module tb_dm_ctrl;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              dm_en;
  logic [ADDR_W-1:0] ar_out;
  logic [16:0]       bus_out;
  logic              end_process;
  logic [DATA_W-1:0] dm_out;
  logic              run_en;
  logic              host_go;
  logic              done;
`ifdef DM_CYCLE_CNT_EN
  logic [CNT_W-1:0]  cycle_count;
`endif

  dm_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hif ();

  dm_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dm_en       (dm_en),
    .ar_out      (ar_out),
    .bus_out     (bus_out),
    .end_process (end_process),
    .dm_out      (dm_out),
    .run_en      (run_en),
    .host        (hif),
    .host_go     (host_go),
`ifdef DM_CYCLE_CNT_EN
    .done        (done),
    .cycle_count (cycle_count)
`else
    .done        (done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=HOST 1=RUN 2=DONE, plus a plain word array.
  int                ph;
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_dm_out;
`ifdef DM_CYCLE_CNT_EN
  logic [CNT_W-1:0]  m_cnt;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_dm_out <= '0;
`ifdef DM_CYCLE_CNT_EN
      m_cnt    <= '0;
`endif
    end else begin
      // Host side: served outside RUN, one read in flight at a time.
      if (ph != 1 && hif.valid && !m_rvalid) begin
        if (hif.we) m_mem[hif.addr[IDX_W-1:0]] <= hif.wdata;
        else        m_rdata <= m_mem[hif.addr[IDX_W-1:0]];
      end
      m_rvalid <= (ph != 1) && hif.valid && !m_rvalid && !hif.we;
      // Core side: read old word, then write.
      if (ph == 1) begin
        m_dm_out <= m_mem[ar_out[IDX_W-1:0]];
        if (dm_en) m_mem[ar_out[IDX_W-1:0]] <= bus_out[DATA_W-1:0];
`ifdef DM_CYCLE_CNT_EN
        if (m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
`endif
      end
      if (ph == 1 && end_process) begin
        ph <= 2;
      end else if (ph != 1 && host_go) begin
        ph <= 1;
`ifdef DM_CYCLE_CNT_EN
        m_cnt <= '0;
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("run_en",      32'(run_en),      32'(ph == 1));
      chk("done",        32'(done),        32'(ph == 2));
      chk("host_ready",  32'(hif.ready),   32'((ph != 1) && !m_rvalid));
      chk("host_rvalid", 32'(hif.rvalid),  32'(m_rvalid));
      chk("host_rdata",  32'(hif.rdata),   32'(m_rdata));
      chk("dm_out",      32'(dm_out),      32'(m_dm_out));
`ifdef DM_CYCLE_CNT_EN
      chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
    end
  end

  // Issue one host request from a negedge; returns at the negedge after acceptance.
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    hif.valid = 1'b1;
    hif.we    = we;
    hif.addr  = a;
    hif.wdata = d;
    while (!hif.ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!hif.ready) chk("host_accept_wait", 32'(hif.ready), 32'd1);
    @(negedge clk);
    hif.valid = 1'b0;
  endtask

  task automatic go();
    host_go = 1'b1;
    @(negedge clk);
    host_go = 1'b0;
  endtask

  initial begin
    dm_en       = 1'b0;
    ar_out      = '0;
    bus_out     = '0;
    end_process = 1'b0;
    host_go     = 1'b0;
    hif.valid   = 1'b0;
    hif.we      = 1'b0;
    hif.addr    = '0;
    hif.wdata   = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_run_en", 32'(run_en),     32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_dm_out", 32'(dm_out),     32'd0);
    chk("rst_rvalid", 32'(hif.rvalid), 32'd0);
    chk("rst_ready",  32'(hif.ready),  32'd1);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Load every word so later reads are all defined.
    for (int i = 0; i < int'(DEPTH); i++) host_op(1'b1, ADDR_W'(i), DATA_W'($urandom));

    // Host write/read with rvalid timing.
    host_op(1'b1, 12'h003, 12'h0A5);
    host_op(1'b0, 12'h003, 12'h000);
    chk("rd_rvalid", 32'(hif.rvalid), 32'd1);
    chk("rd_rdata",  32'(hif.rdata),  32'h0A5);
    chk("rd_ready",  32'(hif.ready),  32'd0);

    // Address wrap.
    host_op(1'b1, 12'h203, 12'h123);
    host_op(1'b0, 12'h003, 12'h000);
    chk("wrap_rdata", 32'(hif.rdata), 32'h123);
    host_op(1'b1, 12'h003, 12'h0A5);
    host_op(1'b1, 12'h020, 12'h3C3);

    // RUN read-first then new data.
    go();
    chk("run_en_on", 32'(run_en), 32'd1);
    ar_out  = 12'h003;
    dm_en   = 1'b1;
    bus_out = 17'h00777;
    @(negedge clk);
    dm_en = 1'b0;
    chk("rdw_old", 32'(dm_out), 32'h0A5);
    @(negedge clk);
    chk("rdw_new", 32'(dm_out), 32'h777);

    // Host ignored in RUN; end_process with a same-cycle write.
    hif.valid = 1'b1;
    hif.we    = 1'b0;
    hif.addr  = 12'h003;
    for (int i = 0; i < 3; i++) begin
      chk("run_no_ready", 32'(hif.ready), 32'd0);
      @(negedge clk);
    end
    hif.valid   = 1'b0;
    ar_out      = 12'h010;
    bus_out     = 17'h00055;
    dm_en       = 1'b1;
    end_process = 1'b1;
    @(negedge clk);
    dm_en       = 1'b0;
    end_process = 1'b0;
    chk("end_done",   32'(done),   32'd1);
    chk("end_run_en", 32'(run_en), 32'd0);
    host_op(1'b0, 12'h010, 12'h000);
    chk("end_wr_rdata", 32'(hif.rdata), 32'h055);

    // Reset in the middle of RUN.
    go();
    for (int i = 0; i < 4; i++) begin
      ar_out = ADDR_W'($urandom);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_run_en", 32'(run_en), 32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    chk("midrst_dm_out", 32'(dm_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    host_op(1'b0, 12'h020, 12'h000);
    chk("midrst_keep_020", 32'(hif.rdata), 32'h3C3);
    host_op(1'b0, 12'h003, 12'h000);
    chk("midrst_keep_003", 32'(hif.rdata), 32'h777);

`ifdef DM_CYCLE_CNT_EN
    go();
    repeat (19) @(negedge clk);
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    chk("cnt_20", 32'(cycle_count), 32'd20);
    go();
    chk("cnt_clear", 32'(cycle_count), 32'd0);
    repeat ((1 << CNT_W) + 4) @(negedge clk);
    end_process = 1'b1;
    @(negedge clk);
    end_process = 1'b0;
    chk("cnt_sat", 32'(cycle_count), 32'hFFFF);
`endif

    // Randomized traffic across all phases.
    for (int i = 0; i < 3000; i++) begin
      hif.valid   = 1'($urandom_range(0, 1));
      hif.we      = 1'($urandom_range(0, 1));
      hif.addr    = ADDR_W'($urandom);
      hif.wdata   = DATA_W'($urandom);
      host_go     = ($urandom_range(0, 19) == 0);
      dm_en       = 1'($urandom_range(0, 1));
      ar_out      = ADDR_W'($urandom);
      bus_out     = 17'($urandom);
      end_process = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    hif.valid   = 1'b0;
    host_go     = 1'b0;
    dm_en       = 1'b0;
    end_process = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
